// File: rtl/xor_stream_parity.sv
// xor_stream_parity: accumulates the bitwise XOR of a word stream over a frame
// delimited by in_last. One result per frame: the XOR word, its parity bit
// and a saturating beat count, handed off over a valid/ready handshake.
//
// Optional build macro XOR_STREAM_CHECK_EN adds in_exp_par / out_err, which
// flag a mismatch between the computed frame parity and an expected parity
// supplied with the last beat.
//
// state | meaning
// ------+--------------------------------------------------------------
// ACCUM | accepting words, folding them into acc and counting beats
// HOLD  | frame result presented on out_*, input stalled until consumed
module xor_stream_parity #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
`ifdef XOR_STREAM_CHECK_EN
  input  logic              in_exp_par,
  output logic              out_err,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_word,
  output logic              out_bit,
  output logic [CNT_W-1:0]  out_beats
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              beat_acc;

  // in_ready depends only on registered state, so out_ready never reaches it
  assign in_ready = (state == ACCUM);

  // next accumulator value and saturating beat count for an accepted beat
  always_comb begin
    beat_acc = in_valid && in_ready;
    acc_next = acc ^ in_data;
    cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  end

  // frame FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_bit   <= 1'b0;
      out_beats <= '0;
`ifdef XOR_STREAM_CHECK_EN
      out_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (beat_acc) begin
            if (in_last) begin
              out_word  <= acc_next;
              out_bit   <= ^acc_next;
              out_beats <= cnt_next;
`ifdef XOR_STREAM_CHECK_EN
              out_err   <= (^acc_next) ^ in_exp_par;
`endif
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              cnt <= cnt_next;
            end
          end
        end
        HOLD: begin
          // result fields keep their values after the handshake; only valid drops
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
